bomberman_cmd_queue: RTL and testbench

Consumer end of the button-debouncer pulse interface. Accepts the five single-cycle SCEN pulses (Up, Down, Left, Right, Middle=bomb) from the debouncers and latches each as a pending request. Serialises pending requests by fixed priority into a small command FIFO. Presents the FIFO head to the game-logic block over a valid/ready handshake, so no button press is lost while game logic is busy (e.g. mid-move or mid-frame).

---
 rtl/bomberman_pkg.sv | 40 ++++
 rtl/bomberman_cmd_fifo.sv | 53 +++++
 rtl/bomberman_cmd_queue.sv | 109 ++++++++++
 tb/tb_bomberman_cmd_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared command codes, source indices and priority order
// Purpose: constants shared by the command queue and the game-logic decoder.
// Ports: none (package).
package bomberman_pkg;

  localparam int NUM_SRC = 5;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_BOMB  = 3'd5;

  // Bit position of each button in the pending register.
  typedef enum logic [2:0] {
    SRC_UP    = 3'd0,
    SRC_DOWN  = 3'd1,
    SRC_LEFT  = 3'd2,
    SRC_RIGHT = 3'd3,
    SRC_BOMB  = 3'd4
  } src_e;

  // Highest priority first.
  localparam src_e PRIO [NUM_SRC] = '{SRC_BOMB, SRC_UP, SRC_DOWN, SRC_LEFT, SRC_RIGHT};

  function automatic logic [2:0] src_code(input src_e s);
    logic [2:0] c;
    case (s)
      SRC_UP:    c = CMD_UP;
      SRC_DOWN:  c = CMD_DOWN;
      SRC_LEFT:  c = CMD_LEFT;
      SRC_RIGHT: c = CMD_RIGHT;
      SRC_BOMB:  c = CMD_BOMB;
      default:   c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bomberman_cmd_fifo.sv
// rtl/bomberman_cmd_fifo.sv - parameterised synchronous command FIFO
// Purpose: stores 3-bit command codes; occupancy kept in a separate counter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write one entry (caller guarantees room, or a same-cycle pop)
//   pop               remove the head (caller guarantees non-empty)
//   head              entry at the read pointer
//   tail              most recently written entry
//   count             current occupancy, 0..DEPTH
module bomberman_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [2:0]       push_data,
  input  logic             pop,
  output logic [2:0]       head,
  output logic [2:0]       tail,
  output logic [PTR_W:0]   count
);

  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is reset too, so the head reads 0 out of reset and nothing stale
  // can surface after a mid-operation reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 3'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign tail = mem[wr_ptr - PTR_W'(1)];

endmodule

// File: rtl/bomberman_cmd_queue.sv
// rtl/bomberman_cmd_queue.sv - button pulse latch, priority serialiser and command FIFO
// Purpose: latches debounced button pulses as pending requests, enqueues them one
//   per cycle by fixed priority, and presents the FIFO head over valid/ready.
// Optional build macro: CMDQ_COALESCE_EN (drop a direction equal to the FIFO tail).
// Ports:
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   ENABLE                       gate for incoming pulses (queue still drains)
//   UP/DOWN/LEFT/RIGHT/MIDDLE_SCEN  single-cycle debounced pulses
//   CMD_VALID, CMD, CMD_READY    head handshake to game logic
//   OVERFLOW, CLR_OVF            sticky merged/lost flag and its clear
//   COUNT                        FIFO occupancy
module bomberman_cmd_queue
  import bomberman_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic             UP_SCEN,
  input  logic             DOWN_SCEN,
  input  logic             LEFT_SCEN,
  input  logic             RIGHT_SCEN,
  input  logic             MIDDLE_SCEN,
  output logic             CMD_VALID,
  output logic [2:0]       CMD,
  input  logic             CMD_READY,
  output logic             OVERFLOW,
  input  logic             CLR_OVF,
  output logic [PTR_W:0]   COUNT
);

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] set_req;
  logic [NUM_SRC-1:0] clr_mask;
  src_e               sel;
  logic               found;
  logic [2:0]         sel_code;
  logic               pop;
  logic               accept;
  logic               discard;
  logic               push;
  logic               ovf_set;
  logic [2:0]         tail;

  assign set_req = {MIDDLE_SCEN, RIGHT_SCEN, LEFT_SCEN, DOWN_SCEN, UP_SCEN} & {NUM_SRC{ENABLE}};

  assign CMD_VALID = (COUNT != '0);
  assign pop       = CMD_VALID && CMD_READY;

  // Highest-priority pending source.
  always_comb begin
    sel   = SRC_BOMB;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && pending[int'(PRIO[i])]) begin
        sel   = PRIO[i];
        found = 1'b1;
      end
    end
  end

  assign sel_code = src_code(sel);
  // A full FIFO can still take an entry when its head leaves this cycle.
  assign accept   = found && ((COUNT != (PTR_W+1)'(DEPTH)) || pop);
  assign clr_mask = accept ? (NUM_SRC'(1) << sel) : '0;

`ifdef CMDQ_COALESCE_EN
  // Repeat of the tail direction is absorbed, unless that tail is leaving now.
  assign discard = (sel != SRC_BOMB) && (COUNT != '0) && (tail == sel_code)
                   && !((COUNT == (PTR_W+1)'(1)) && pop);
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign discard     = 1'b0;
`endif

  assign push = accept && !discard;

  // A re-pulse of a bit being consumed this cycle is a fresh request, not a merge.
  assign ovf_set = |(set_req & pending & ~clr_mask);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending  <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_req;
      if (ovf_set)      OVERFLOW <= 1'b1;
      else if (CLR_OVF) OVERFLOW <= 1'b0;
    end
  end

  bomberman_cmd_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .push      (push),
    .push_data (sel_code),
    .pop       (pop),
    .head      (CMD),
    .tail      (tail),
    .count     (COUNT)
  );

endmodule

// File: tb/tb_bomberman_cmd_queue.sv
// tb/tb_bomberman_cmd_queue.sv - self-checking bench for bomberman_cmd_queue
module tb_bomberman_cmd_queue;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       ENABLE;
  logic       UP_SCEN, DOWN_SCEN, LEFT_SCEN, RIGHT_SCEN, MIDDLE_SCEN;
  logic       CMD_VALID;
  logic [2:0] CMD;
  logic       CMD_READY;
  logic       OVERFLOW;
  logic       CLR_OVF;
  logic [2:0] COUNT;

  bomberman_cmd_queue #(.DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
    .UP_SCEN     (UP_SCEN),
    .DOWN_SCEN   (DOWN_SCEN),
    .LEFT_SCEN   (LEFT_SCEN),
    .RIGHT_SCEN  (RIGHT_SCEN),
    .MIDDLE_SCEN (MIDDLE_SCEN),
    .CMD_VALID   (CMD_VALID),
    .CMD         (CMD),
    .CMD_READY   (CMD_READY),
    .OVERFLOW    (OVERFLOW),
    .CLR_OVF     (CLR_OVF),
    .COUNT       (COUNT)
  );

  always #5 CLK = ~CLK;

  // Source index: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 BOMB (MIDDLE).
  localparam logic [4:0] P_U = 5'b00001, P_D = 5'b00010, P_L = 5'b00100,
                         P_R = 5'b01000, P_M = 5'b10000, P_0 = 5'b00000;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: list of queued codes, set of pending sources, sticky flag.
  int  mq[$];
  bit  mpend[5];
  bit  movf;
  int  prio[5]    = '{4, 0, 1, 2, 3};
  int  code_of[5] = '{1, 2, 3, 4, 5};

  int  popped[$];
  int  pop_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 5; i++) mpend[i] = 0;
    movf = 0;
  endtask

  task automatic model_step(input logic [4:0] p, input logic en, input logic rdy, input logic clr);
    bit pop_now, can, disc, ovfset;
    int sel;
    pop_now = (mq.size() != 0) && rdy;
    can     = (mq.size() < DEPTH) || pop_now;
    sel     = -1;
    for (int k = 0; k < 5; k++)
      if (sel < 0 && mpend[prio[k]]) sel = prio[k];
    disc = 0;
    if (sel >= 0 && can) begin
`ifdef CMDQ_COALESCE_EN
      if (sel != 4 && mq.size() != 0 && mq[$] == code_of[sel] && !(mq.size() == 1 && pop_now))
        disc = 1;
`endif
      mpend[sel] = 0;
    end
    if (pop_now) void'(mq.pop_front());
    if (sel >= 0 && can && !disc) mq.push_back(code_of[sel]);
    ovfset = 0;
    for (int i = 0; i < 5; i++) begin
      if (p[i] && en) begin
        if (mpend[i]) ovfset = 1;
        mpend[i] = 1;
      end
    end
    if (ovfset) movf = 1;
    else if (clr) movf = 0;
  endtask

  // One clock: drive inputs, compare registered outputs with the model, advance.
  task automatic cycle(input logic [4:0] p, input logic en, input logic rdy, input logic clr);
    UP_SCEN = p[0]; DOWN_SCEN = p[1]; LEFT_SCEN = p[2]; RIGHT_SCEN = p[3]; MIDDLE_SCEN = p[4];
    ENABLE = en; CMD_READY = rdy; CLR_OVF = clr;
    #1;
    chk("valid", CMD_VALID, mq.size() != 0);
    if (mq.size() != 0) chk("cmd", CMD, mq[0]);
    chk("count", COUNT, mq.size());
    chk("overflow", OVERFLOW, movf);
    if (CMD_VALID && rdy) begin
      popped.push_back(int'(CMD));
      pop_cyc.push_back(cyc);
    end
    model_step(p, en, rdy, clr);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(P_0, 1'b1, rdy, 1'b0);
  endtask

  task automatic chk_seq(input string tag, input int exp[$]);
    chk({tag, "_len"}, popped.size(), exp.size());
    for (int i = 0; i < exp.size() && i < popped.size(); i++)
      chk(tag, popped[i], exp[i]);
  endtask

  int start;

  initial begin
    model_reset();
    RESET_N = 1'b0;
    ENABLE = 1'b1; CMD_READY = 1'b0; CLR_OVF = 1'b0;
    UP_SCEN = 0; DOWN_SCEN = 0; LEFT_SCEN = 0; RIGHT_SCEN = 0; MIDDLE_SCEN = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", CMD_VALID, 0);
    chk("rst_cmd", CMD, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_ovf", OVERFLOW, 0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Single UP: valid for exactly one cycle, two cycles after the pulse.
    idle(2, 1'b1);
    popped.delete(); pop_cyc.delete();
    start = cyc;
    cycle(P_U, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1);
    chk_seq("single_up", '{1});
    if (pop_cyc.size() == 1) chk("up_latency", pop_cyc[0] - start, 2);
    chk("up_ovf", OVERFLOW, 0);

    // Simultaneous MIDDLE, LEFT, DOWN drain in priority order on back-to-back cycles.
    popped.delete(); pop_cyc.delete();
    cycle(P_M | P_L | P_D, 1'b1, 1'b1, 1'b0);
    idle(6, 1'b1);
    chk_seq("prio", '{5, 2, 3});
    if (pop_cyc.size() == 3) chk("prio_b2b", pop_cyc[2] - pop_cyc[0], 2);

    // Fill while stalled, merge two LEFT presses, then drain with nothing lost.
    popped.delete(); pop_cyc.delete();
    cycle(P_U, 1'b1, 1'b0, 1'b0);
    cycle(P_D, 1'b1, 1'b0, 1'b0);
    cycle(P_L, 1'b1, 1'b0, 1'b0);
    cycle(P_R, 1'b1, 1'b0, 1'b0);
    cycle(P_M, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("full_count", COUNT, DEPTH);
    cycle(P_L, 1'b1, 1'b0, 1'b0);
    cycle(P_0, 1'b1, 1'b0, 1'b0);
    cycle(P_L, 1'b1, 1'b0, 1'b0);
    chk("merge_ovf", OVERFLOW, 1);
    idle(10, 1'b1);
    chk_seq("drain", '{1, 2, 3, 4, 5, 3});
    cycle(P_0, 1'b1, 1'b1, 1'b1);
    chk("clr_ovf", OVERFLOW, 0);

    // Pulses ignored while disabled.
    cycle(P_U | P_R, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("disabled_count", COUNT, 0);

    // Two RIGHT presses 15 cycles apart while stalled.
    cycle(P_R, 1'b1, 1'b0, 1'b0);
    idle(14, 1'b0);
    cycle(P_R, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);
`ifdef CMDQ_COALESCE_EN
    chk("coalesce_count", COUNT, 1);
`else
    chk("coalesce_count", COUNT, 2);
`endif
    chk("coalesce_cmd", CMD, 4);
    idle(6, 1'b1);

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [4:0] p;
      for (int b = 0; b < 5; b++) p[b] = ($urandom_range(7) == 0);
      cycle(p, $urandom_range(9) != 0, $urandom_range(2) != 0, $urandom_range(15) == 0);
    end
    idle(12, 1'b1);

    // Asynchronous reset mid-operation: COUNT=3, sources pending, OVERFLOW set.
    cycle(P_U | P_D | P_L | P_R | P_M, 1'b1, 1'b0, 1'b0);
    cycle(P_U, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    chk("pre_rst_count", COUNT, 3);
    chk("pre_rst_ovf", OVERFLOW, 1);
    RESET_N = 1'b0;
    #1;
    chk("arst_valid", CMD_VALID, 0);
    chk("arst_cmd", CMD, 0);
    chk("arst_count", COUNT, 0);
    chk("arst_ovf", OVERFLOW, 0);
    model_reset();
    #1;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    popped.delete();
    idle(8, 1'b1);
    chk("post_rst_pops", popped.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
